wja_bus_lite_master: RTL

WJA_BUS_LITE_MASTER -- requirements
Module: wja_bus_lite_master
Interface
REQ-001 SHALL have parameter ADDR_W, default 5, AXI4-Lite byte-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, cycles allowed per transaction before abort.
REQ-003 m00_axi_aclk  input  1  single clock; all logic on rising edge.
REQ-004 m00_axi_aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  ADDR_W  byte address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 cmd_wstrb  input  4  write byte strobes.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  read data, valid with rsp_valid.
REQ-013 rsp_resp  output  2  bresp/rresp of the transaction.
REQ-014 rsp_timeout  output  1  transaction aborted by timeout.
REQ-015 m00_axi_awaddr  output  ADDR_W  write address.
REQ-016 m00_axi_awprot, m00_axi_arprot  output  3  constant 3'b000.
REQ-017 m00_axi_awvalid / m00_axi_awready  output / input  1  AW handshake.
REQ-018 m00_axi_wdata  output  32  write data.
REQ-019 m00_axi_wstrb  output  4  write strobes.
REQ-020 m00_axi_wvalid / m00_axi_wready  output / input  1  W handshake.
REQ-021 m00_axi_bresp  input  2  write response.
REQ-022 m00_axi_bvalid / m00_axi_bready  input / output  1  B handshake.
REQ-023 m00_axi_araddr  output  ADDR_W  read address.
REQ-024 m00_axi_arvalid / m00_axi_arready  output / input  1  AR handshake.
REQ-025 m00_axi_rdata  input  32  read data.
REQ-026 m00_axi_rresp  input  2  read response.
REQ-027 m00_axi_rvalid / m00_axi_rready  input / output  1  R handshake.
Function
REQ-028 FSM states IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE; one transaction outstanding at a time; all AXI and rsp outputs registered.
REQ-029 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready, addr/wdata/wstrb/write captured, next state WR_AW_W (write) or RD_AR (read).
REQ-030 WR_AW_W: awvalid and wvalid rise together the cycle after acceptance; each drops the cycle after its own handshake; awready/wready same or any order accepted; both done -> WR_B.
REQ-031 WR_B: bready=1; on bvalid capture bresp -> DONE; bready low outside WR_B (bvalid ignored).
REQ-032 RD_AR: arvalid=1 until arready -> RD_R; RD_R: rready=1 until rvalid, capture rdata/rresp -> DONE.
REQ-033 DONE: rsp_valid=1 for exactly one cycle, then IDLE; zero-wait slave gives acceptance-to-rsp_valid latency of 3 cycles (read and write), cmd_ready high again cycle 4.
REQ-034 Valid signals and their payloads SHALL remain stable until handshake (AXI rule), except on timeout abort.
REQ-035 Timeout counter clears on acceptance, increments each non-IDLE cycle; reaching TIMEOUT -> drop all valid/ready, go DONE with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-036 rsp_rdata=0 for writes; rsp_timeout=0 on normal completion.
Reset
REQ-037 aresetn low SHALL immediately force IDLE and all outputs to 0 except cmd_ready (1 after deassert) and prot (0), aborting any transaction silently (no rsp_valid).
Structure
REQ-038 FSM state enum and AXI response codes (OKAY=0, SLVERR=2) SHALL live in a shared package wja_axi_pkg.
REQ-039 No sub-module; single flat module.
Verification
REQ-040 Write 0xDEADBEEF, addr 0x00, wstrb 4'hF into wja_bus_lite -> reg0=0xDEADBEEF, rsp_resp=0, rsp_valid 3 cycles after accept.
REQ-041 Read addr 0x00 after REQ-040 -> rsp_rdata=0xDEADBEEF, rsp_resp=0.
REQ-042 Write 0x12345678, wstrb 4'b0011 over 0xDEADBEEF -> read back 0xDEAD5678.
REQ-043 Stub slave never asserts awready, TIMEOUT=16 -> rsp_valid with rsp_timeout=1, rsp_resp=2 exactly 16 cycles after acceptance; next command proceeds normally.
REQ-044 Slave delays wready 5 cycles after awready -> awvalid drops after AW handshake, wvalid held stable, single correct rsp_valid.
REQ-045 aresetn pulsed low in WR_B -> all valids 0 immediately, no rsp_valid, cmd_ready=1 one cycle after release.

---
 rtl/wja_axi_pkg.sv | 28 ++
 rtl/wja_bus_lite_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wja_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module : wja_axi_pkg
// Brief  : Shared types and AXI4-Lite response codes for the bus-lite master.
// Rev    : 1.0  initial release
// ============================================================================
package wja_axi_pkg;

  // Sequencer states of the single-outstanding AXI4-Lite master
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_DONE    = 3'd5
  } wja_state_t;

  // AXI response encodings used by the master and its peers
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Fixed data path geometry of the lite bus
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

endpackage
`default_nettype wire

// File: rtl/wja_bus_lite_master.sv
`default_nettype none
// ============================================================================
// Module : wja_bus_lite_master
// Brief  : Command-to-AXI4-Lite master. Accepts one read or write command at
//          a time, runs the AXI handshakes, and returns a one-cycle response
//          pulse. A per-transaction watchdog aborts stalled transfers.
// Rev    : 1.0  initial release
// ============================================================================
module wja_bus_lite_master
  import wja_axi_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                m00_axi_aclk,
  input  logic                m00_axi_aresetn,
  // command side
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [STRB_W-1:0]   cmd_wstrb,
  // response side
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  // AXI write address
  output logic [ADDR_W-1:0]   m00_axi_awaddr,
  output logic [2:0]          m00_axi_awprot,
  output logic                m00_axi_awvalid,
  input  logic                m00_axi_awready,
  // AXI write data
  output logic [DATA_W-1:0]   m00_axi_wdata,
  output logic [STRB_W-1:0]   m00_axi_wstrb,
  output logic                m00_axi_wvalid,
  input  logic                m00_axi_wready,
  // AXI write response
  input  logic [1:0]          m00_axi_bresp,
  input  logic                m00_axi_bvalid,
  output logic                m00_axi_bready,
  // AXI read address
  output logic [ADDR_W-1:0]   m00_axi_araddr,
  output logic [2:0]          m00_axi_arprot,
  output logic                m00_axi_arvalid,
  input  logic                m00_axi_arready,
  // AXI read data
  input  logic [DATA_W-1:0]   m00_axi_rdata,
  input  logic [1:0]          m00_axi_rresp,
  input  logic                m00_axi_rvalid,
  output logic                m00_axi_rready
);

  // Watchdog counter holds (cycles since acceptance - 1); aborting when it
  // reaches TIMEOUT-2 places the DONE cycle exactly TIMEOUT cycles after
  // acceptance. TIMEOUT must be at least 3.
  localparam int                TCNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_ABORT = TCNT_W'(TIMEOUT - 2);

  wja_state_t        state;
  logic [TCNT_W-1:0] tcnt;
  logic              aw_done;
  logic              w_done;

  logic              aw_hs;
  logic              w_hs;
  logic              aw_ok;
  logic              w_ok;
  logic              tmo_hit;
  logic              abort;

  // Unprivileged, secure, data accesses only
  assign m00_axi_awprot = 3'b000;
  assign m00_axi_arprot = 3'b000;

  assign aw_hs   = m00_axi_awvalid && m00_axi_awready;
  assign w_hs    = m00_axi_wvalid  && m00_axi_wready;
  assign aw_ok   = aw_done || aw_hs;
  assign w_ok    = w_done  || w_hs;
  assign tmo_hit = (tcnt == TCNT_ABORT);

  // Abort only while still waiting; a response arriving on the last allowed
  // cycle is taken as a normal completion
  always_comb begin
    abort = 1'b0;
    case (state)
      ST_WR_AW_W, ST_RD_AR: abort = tmo_hit;
      ST_WR_B:              abort = tmo_hit && !m00_axi_bvalid;
      ST_RD_R:              abort = tmo_hit && !m00_axi_rvalid;
      default:              abort = 1'b0;
    endcase
  end

  // Transaction sequencer: one command in flight, all AXI/rsp outputs registered
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state           <= ST_IDLE;
      tcnt            <= '0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      cmd_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_resp        <= RESP_OKAY;
      rsp_timeout     <= 1'b0;
      m00_axi_awaddr  <= '0;
      m00_axi_awvalid <= 1'b0;
      m00_axi_wdata   <= '0;
      m00_axi_wstrb   <= '0;
      m00_axi_wvalid  <= 1'b0;
      m00_axi_bready  <= 1'b0;
      m00_axi_araddr  <= '0;
      m00_axi_arvalid <= 1'b0;
      m00_axi_rready  <= 1'b0;
    end else if (abort) begin
      // Watchdog expiry: withdraw every valid/ready and report an error
      m00_axi_awvalid <= 1'b0;
      m00_axi_wvalid  <= 1'b0;
      m00_axi_arvalid <= 1'b0;
      m00_axi_bready  <= 1'b0;
      m00_axi_rready  <= 1'b0;
      rsp_valid       <= 1'b1;
      rsp_timeout     <= 1'b1;
      rsp_resp        <= RESP_SLVERR;
      rsp_rdata       <= '0;
      state           <= ST_DONE;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            tcnt        <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_timeout <= 1'b0;
            if (cmd_write) begin
              m00_axi_awaddr  <= cmd_addr;
              m00_axi_wdata   <= cmd_wdata;
              m00_axi_wstrb   <= cmd_wstrb;
              m00_axi_awvalid <= 1'b1;
              m00_axi_wvalid  <= 1'b1;
              state           <= ST_WR_AW_W;
            end else begin
              m00_axi_araddr  <= cmd_addr;
              m00_axi_arvalid <= 1'b1;
              state           <= ST_RD_AR;
            end
          end
        end

        ST_WR_AW_W: begin
          tcnt <= tcnt + 1'b1;
          // AW and W channels complete independently, in either order
          if (aw_hs) begin
            m00_axi_awvalid <= 1'b0;
            aw_done         <= 1'b1;
          end
          if (w_hs) begin
            m00_axi_wvalid <= 1'b0;
            w_done         <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            m00_axi_bready <= 1'b1;
            state          <= ST_WR_B;
          end
        end

        ST_WR_B: begin
          tcnt <= tcnt + 1'b1;
          if (m00_axi_bvalid && m00_axi_bready) begin
            m00_axi_bready <= 1'b0;
            rsp_resp       <= m00_axi_bresp;
            rsp_rdata      <= '0;
            rsp_valid      <= 1'b1;
            state          <= ST_DONE;
          end
        end

        ST_RD_AR: begin
          tcnt <= tcnt + 1'b1;
          if (m00_axi_arvalid && m00_axi_arready) begin
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b1;
            state           <= ST_RD_R;
          end
        end

        ST_RD_R: begin
          tcnt <= tcnt + 1'b1;
          if (m00_axi_rvalid && m00_axi_rready) begin
            m00_axi_rready <= 1'b0;
            rsp_rdata      <= m00_axi_rdata;
            rsp_resp       <= m00_axi_rresp;
            rsp_valid      <= 1'b1;
            state          <= ST_DONE;
          end
        end

        ST_DONE: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
